// File: rtl/fifo_read_stream_adapter_pkg.sv
// Shared definitions for the read side of the asynchronous FIFO:
// default widths, memory read latency and a pointer-width helper.
package fifo_read_stream_adapter_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int FIFO_RD_LATENCY    = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_stream_buffer.sv
// Small circular buffer that turns pushed words into a valid/ready stream.
// Pointers carry an extra wrap bit so level is a plain modular subtraction.
module fifo_stream_buffer
   import fifo_read_stream_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BUF_DEPTH  = 4,
   localparam int PTR_W     = clog2(BUF_DEPTH) + 1
) (
   input  logic                  r_clk,
   input  logic                  rrst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic [PTR_W-1:0]      level
);

   localparam int AW = PTR_W - 1;

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  pop;

   assign pop = m_valid & m_ready;

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge r_clk) begin
      if (!rrst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are live.
   always_ff @(posedge r_clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign level   = wr_ptr - rd_ptr;
   assign m_valid = (level != '0);
   // Zero while empty so stale storage never shows on the stream after reset.
   assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// Read-end consumer of the async FIFO: issues credit-limited reads, tracks
// them through a latency pipe and lands the data in a local stream buffer.
module fifo_read_stream_adapter
   import fifo_read_stream_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int RD_LATENCY = FIFO_RD_LATENCY,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                  r_clk,
   input  logic                  rrst_n,
   input  logic                  rd_enable,
   input  logic                  r_empty,
   output logic                  r_en,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  idle
);

   localparam int PTR_W = clog2(BUF_DEPTH) + 1;

   logic [RD_LATENCY-1:0] pipe;
   logic [PTR_W-1:0]      inflight;
   logic [PTR_W-1:0]      level;
   logic [PTR_W:0]        committed;
   logic                  acc;
   logic                  push;

   // NOTE: assign a default before the loop so no path leaves inflight unassigned.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + PTR_W'(pipe[i]);
   end

   // Credit uses registered level only; a same-cycle pop frees space next cycle.
   assign committed = {1'b0, level} + {1'b0, inflight};
   assign r_en      = rrst_n & rd_enable & ~r_empty & (committed < (PTR_W+1)'(BUF_DEPTH));
   assign acc       = r_en & ~r_empty;

   always_ff @(posedge r_clk) begin
      if (!rrst_n) begin
         pipe <= '0;
      end else begin
         pipe[0] <= acc;
         for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign push = pipe[RD_LATENCY-1];
   assign idle = (inflight == '0) & ~m_valid;

   fifo_stream_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .r_clk   (r_clk),
      .rrst_n  (rrst_n),
      .push    (push),
      .wr_data (r_data),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .level   (level)
   );

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Directed bench: a small FIFO model with fixed read latency feeds the adapter,
// and every popped word is compared against the order of accepted reads.
module tb_fifo_read_stream_adapter;

   localparam int DW = 8;
   localparam int L  = 2;
   localparam int D  = 4;

   logic          r_clk;
   logic          rrst_n;
   logic          rd_enable;
   logic          r_empty;
   logic          r_en;
   logic [DW-1:0] r_data;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          idle;

   fifo_read_stream_adapter #(
      .DATA_WIDTH (DW),
      .RD_LATENCY (L),
      .BUF_DEPTH  (D)
   ) dut (
      .r_clk     (r_clk),
      .rrst_n    (rrst_n),
      .rd_enable (rd_enable),
      .r_empty   (r_empty),
      .r_en      (r_en),
      .r_data    (r_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .idle      (idle)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] fifo_q [$];
   logic [DW-1:0] exp_q  [$];
   logic [DW-1:0] dly    [L];
   logic          gap;
   int            cyc;
   int            acc_cnt, pop_cnt;
   int            first_acc, last_acc, first_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic update_empty();
      r_empty = (fifo_q.size() == 0) || gap;
   endtask

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
      update_empty();
   endtask

   task automatic clear_stats();
      acc_cnt = 0; pop_cnt = 0;
      first_acc = -1; last_acc = -1; first_valid = -1;
   endtask

   // One clock: sample mid-cycle, then advance the FIFO model after the edge.
   task automatic step();
      logic          s_acc, s_pop;
      logic [DW-1:0] s_data, w;
      #4;
      s_acc  = r_en & ~r_empty;
      s_pop  = m_valid & m_ready & rrst_n;
      s_data = m_data;
      if (r_empty) check("no_read_when_empty", r_en, 1'b0);
      if (m_valid === 1'b1 && first_valid < 0 && rrst_n) first_valid = cyc;
      if (s_pop) begin
         pop_cnt++;
         if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
         else check("pop_order", s_data, exp_q.pop_front());
      end
      @(posedge r_clk);
      #1;
      for (int i = L - 1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = 8'hEE;
      if (!rrst_n) begin
         exp_q.delete();
         for (int i = 0; i < L; i++) dly[i] = 8'hEE;
      end else if (s_acc) begin
         w = fifo_q.pop_front();
         dly[0] = w;
         exp_q.push_back(w);
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
         acc_cnt++;
         check("no_push_when_full", exp_q.size() <= D, 1'b1);
      end
      r_data = dly[L-1];
      cyc++;
      update_empty();
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      fifo_q.delete();
      update_empty();
      step();
      rrst_n = 1'b1;
      clear_stats();
   endtask

   initial begin
      rrst_n = 1'b0; rd_enable = 1'b1; m_ready = 1'b0; gap = 1'b0;
      r_data = '0; cyc = 0;
      for (int i = 0; i < L; i++) dly[i] = 8'hEE;
      clear_stats();

      // Reset held with data available and reads enabled.
      load(8'h01, 16);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_r_en", r_en, 1'b0);
         check("rst_m_valid", m_valid, 1'b0);
         check("rst_idle", idle, 1'b1);
      end
      check("rst_m_data", m_data, 8'h00);
      do_reset();

      // Streaming at full rate.
      m_ready = 1'b1;
      load(8'h01, 16);
      for (int i = 0; i < 30; i++) step();
      check("stream_acc_count", acc_cnt, 16);
      check("stream_acc_back_to_back", last_acc - first_acc, 15);
      check("stream_first_latency", first_valid - first_acc, L + 1);
      check("stream_pop_count", pop_cnt, 16);
      check("stream_idle", idle, 1'b1);
      do_reset();

      // Back-pressure: credit limits reads to the buffer depth.
      m_ready = 1'b0;
      load(8'h01, 16);
      for (int i = 0; i < 10; i++) step();
      check("bp_acc_count", acc_cnt, D);
      check("bp_r_en_low", r_en, 1'b0);
      check("bp_m_valid", m_valid, 1'b1);
      check("bp_head_held", m_data, 8'h01);
      m_ready = 1'b1;
      for (int i = 0; i < 40 && pop_cnt < 16; i++) step();
      check("bp_pop_count", pop_cnt, 16);
      step();
      check("bp_idle", idle, 1'b1);
      do_reset();

      // Empty gaps every two cycles.
      load(8'h30, 12);
      for (int i = 0; i < 100 && pop_cnt < 12; i++) begin
         gap = ((i / 2) % 2) == 0;
         update_empty();
         step();
      end
      gap = 1'b0;
      update_empty();
      check("gap_pop_count", pop_cnt, 12);
      step();
      check("gap_idle", idle, 1'b1);
      do_reset();

      // Pause after five accepted reads.
      load(8'h50, 16);
      for (int i = 0; i < 20 && acc_cnt < 5; i++) step();
      check("pause_reached_5", acc_cnt, 5);
      rd_enable = 1'b0;
      for (int i = 0; i < L + 2 && !idle; i++) step();
      check("pause_idle_in_time", idle, 1'b1);
      check("pause_pop_count", pop_cnt, 5);
      for (int i = 0; i < 4; i++) step();
      check("pause_no_new_acc", acc_cnt, 5);
      rd_enable = 1'b1;
      do_reset();

      // Reset with words both in flight and buffered.
      m_ready = 1'b0;
      load(8'h70, 16);
      for (int i = 0; i < 20 && acc_cnt < D; i++) step();
      check("mid_m_valid_before", m_valid, 1'b1);
      check("mid_busy_before", idle, 1'b0);
      do_reset();
      check("mid_m_valid", m_valid, 1'b0);
      check("mid_idle", idle, 1'b1);
      check("mid_m_data", m_data, 8'h00);
      m_ready = 1'b1;
      load(8'hA0, 8);
      for (int i = 0; i < 40 && pop_cnt < 8; i++) step();
      check("mid_restart_pops", pop_cnt, 8);
      step();
      check("mid_restart_idle", idle, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
